// File: rtl/messbauer_sweep_controller.sv
// rtl/messbauer_sweep_controller.sv - Mossbauer velocity sweep sequencer
module messbauer_sweep_controller #(
    parameter int DATA_WIDTH  = 12,
    parameter int TIMER_WIDTH = 16,
    parameter int COUNT_WIDTH = 16,
    parameter logic [TIMER_WIDTH-1:0] DEF_CHANNEL_DURATION = 3200,
    parameter logic [DATA_WIDTH-1:0]  DEF_DIRECT_CHANNELS  = 512,
    parameter logic [DATA_WIDTH-1:0]  DEF_REVERSE_STEP     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [TIMER_WIDTH-1:0] cfg_channel_duration,
    input  logic [DATA_WIDTH-1:0]  cfg_direct_channels,
    input  logic [DATA_WIDTH-1:0]  cfg_reverse_step,
    output logic                   cfg_error,
    input  logic                   start,
    input  logic                   stop,
    output logic                   busy,
    output logic                   dir,
    output logic [DATA_WIDTH-1:0]  channel,
    output logic                   channel_strobe,
    output logic                   cycle_start,
    output logic [COUNT_WIDTH-1:0] cycle_count
);

    typedef enum logic [1:0] {IDLE, DIRECT, REVERSE} state_t;

    localparam logic [TIMER_WIDTH-1:0] ONE_T = 1;
    localparam logic [DATA_WIDTH-1:0]  ONE_D = 1;
    localparam logic [COUNT_WIDTH-1:0] ONE_C = 1;

    state_t                 state, state_nx;
    logic [TIMER_WIDTH-1:0] timer, timer_nx;
    logic [TIMER_WIDTH-1:0] duration, duration_nx;
    logic [DATA_WIDTH-1:0]  direct_channels, direct_channels_nx;
    logic [DATA_WIDTH-1:0]  reverse_step, reverse_step_nx;
    logic [DATA_WIDTH-1:0]  channel_nx;
    logic [COUNT_WIDTH-1:0] cycle_count_nx;
    logic                   dir_nx;
    logic                   stop_pending, stop_pending_nx;
    logic                   channel_strobe_nx, cycle_start_nx, cfg_error_nx;
    logic                   cfg_fire, cfg_bad, timer_end;

    assign cfg_fire  = cfg_valid && (state == IDLE);
    assign cfg_bad   = (cfg_channel_duration == '0) || (cfg_direct_channels == '0) ||
                       (cfg_reverse_step == '0) || (cfg_reverse_step > cfg_direct_channels);
    assign timer_end = (timer == duration - ONE_T);

    always_comb begin
        state_nx           = state;
        timer_nx           = timer;
        duration_nx        = duration;
        direct_channels_nx = direct_channels;
        reverse_step_nx    = reverse_step;
        channel_nx         = channel;
        cycle_count_nx     = cycle_count;
        dir_nx             = dir;
        stop_pending_nx    = stop_pending;
        channel_strobe_nx  = 1'b0;
        cycle_start_nx     = 1'b0;
        cfg_error_nx       = 1'b0;

        case (state)
            IDLE: begin
                if (cfg_fire) begin
                    if (cfg_bad) begin
                        cfg_error_nx = 1'b1;
                    end else begin
                        duration_nx        = cfg_channel_duration;
                        direct_channels_nx = cfg_direct_channels;
                        reverse_step_nx    = cfg_reverse_step;
                    end
                end
                if (start) begin
                    state_nx          = DIRECT;
                    timer_nx          = '0;
                    channel_nx        = '0;
                    dir_nx            = 1'b0;
                    cycle_count_nx    = '0;
                    stop_pending_nx   = 1'b0;
                    cycle_start_nx    = 1'b1;
                    channel_strobe_nx = 1'b1;
                end
            end
            DIRECT: begin
                if (stop)
                    stop_pending_nx = 1'b1;
                if (timer_end) begin
                    timer_nx = '0;
                    if (channel < direct_channels - ONE_D) begin
                        channel_nx        = channel + ONE_D;
                        channel_strobe_nx = 1'b1;
                    end else begin
                        state_nx = REVERSE;
                        dir_nx   = 1'b1;
                    end
                end else begin
                    timer_nx = timer + ONE_T;
                end
            end
            REVERSE: begin
                if (stop)
                    stop_pending_nx = 1'b1;
                if (timer_end) begin
                    timer_nx = '0;
                    if (channel > reverse_step) begin
                        channel_nx = channel - reverse_step;
                    end else begin
                        // Cycle boundary: a stop seen on this very clock still takes effect.
                        channel_nx = '0;
                        dir_nx     = 1'b0;
                        if (cycle_count != '1)
                            cycle_count_nx = cycle_count + ONE_C;
                        if (stop_pending || stop) begin
                            state_nx        = IDLE;
                            stop_pending_nx = 1'b0;
                        end else begin
                            state_nx          = DIRECT;
                            cycle_start_nx    = 1'b1;
                            channel_strobe_nx = 1'b1;
                        end
                    end
                end else begin
                    timer_nx = timer + ONE_T;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            timer           <= '0;
            duration        <= DEF_CHANNEL_DURATION;
            direct_channels <= DEF_DIRECT_CHANNELS;
            reverse_step    <= DEF_REVERSE_STEP;
            channel         <= '0;
            cycle_count     <= '0;
            dir             <= 1'b0;
            stop_pending    <= 1'b0;
            channel_strobe  <= 1'b0;
            cycle_start     <= 1'b0;
            cfg_error       <= 1'b0;
            busy            <= 1'b0;
            cfg_ready       <= 1'b1;
        end else begin
            state           <= state_nx;
            timer           <= timer_nx;
            duration        <= duration_nx;
            direct_channels <= direct_channels_nx;
            reverse_step    <= reverse_step_nx;
            channel         <= channel_nx;
            cycle_count     <= cycle_count_nx;
            dir             <= dir_nx;
            stop_pending    <= stop_pending_nx;
            channel_strobe  <= channel_strobe_nx;
            cycle_start     <= cycle_start_nx;
            cfg_error       <= cfg_error_nx;
            busy            <= (state_nx != IDLE);
            cfg_ready       <= (state_nx == IDLE);
        end
    end

endmodule
